clz_seq: RTL
============

// Module: clz_seq
// PURPOSE
//  Multi-cycle count-leading-zeros unit for the CPU54 ALU; serves the MIPS CLZ (and CLO) instructions.
//  Scans the operand STEP bits per cycle from the MSB and stops early at the first set bit.
//  Uses a start/busy/done handshake so the control unit stalls the pipeline while busy.
//  Generalises the combinational 5-bit CLZ to any WIDTH and trades area for latency through STEP.
// PARAMETERS
//  WIDTH  32                   operand width in bits; must be a multiple of STEP
//  STEP   4                    bits examined per scan cycle (1..WIDTH)
//  CNT_W  $clog2(WIDTH+1)      result width; derived, never overridden
// PORTS
//  clk      in   1      rising-edge clock
//  rst_n    in   1      asynchronous reset, active low
//  start    in   1      request; sampled only in IDLE
//  datain   in   WIDTH  operand; sampled on the start cycle only
//  mode     in   1      0=CLZ, 1=CLO; port exists only with CLZ_CLO_EN
//  busy     out  1      high in SCAN and DONE
//  done     out  1      one-cycle pulse when dataout becomes valid
//  dataout  out  CNT_W  leading-zero count; held until the next accepted start
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, busy=0, done=0, dataout=0, shift register=0, count=0.
//  FSM has three states: IDLE, SCAN and DONE.
//   IDLE: when start=1, latch sh<=datain (inverted when CLO), cnt<=0, idx<=0, go to SCAN.
//   SCAN: chunk = sh[WIDTH-1 -: STEP].
//     If chunk is non-zero: cnt<=cnt+lz(chunk), go to DONE.
//     Else: cnt<=cnt+STEP, sh<=sh<<STEP, idx<=idx+1.
//       When this was the last chunk (idx==WIDTH/STEP-1), go to DONE.
//   DONE: dataout<=cnt, done=1 for this one cycle, return to IDLE.
//  Latency from the start edge to the done pulse is (chunks scanned + 1) cycles.
//   Best case is 2 cycles. Worst case is WIDTH/STEP+1 cycles, e.g. 9 for 32/4.
//  Zero operand: result = WIDTH (32 fits in CNT_W=6). Nothing wraps or saturates.
//  A start while busy is ignored: there is no queue and the operand is not latched.
//  start asserted in the DONE cycle is also ignored. A new op is accepted from IDLE only,
//   so back-to-back ops have a 1-cycle gap.
//  dataout is stable from the done pulse until the DONE state of the next op.
//  Reset during SCAN aborts the op. No done pulse is issued; dataout=0.
//  An elaboration-time $error fires if WIDTH%STEP!=0 or STEP<1.
// CONFIGURATION
//  Macro CLZ_CLO_EN.
//   Defined: the mode port exists. With mode=1 the operand is bit-inverted at latch time,
//    so the unit counts leading ones. mode is sampled with start.
//   Undefined: there is no mode port and the unit is CLZ only. Timing is identical.
// STRUCTURE
//  Package clz_pkg holds:
//   the state enum clz_state_t {IDLE, SCAN, DONE};
//   the function clz_cnt_w(width) returning $clog2(width+1).
//  Sub-module clz_chunk #(STEP): a combinational priority encoder. Input is in[STEP-1:0].
//   Outputs are lz[$clog2(STEP+1)-1:0] and nz (in!=0).
//  The top level holds the FSM, the shift register, cnt and idx.
// TESTING  (WIDTH=32, STEP=4; t0 = the start edge)
//  1. datain=32'h8000_0000 -> dataout=0, done at t0+2, busy high for 2 cycles.
//  2. datain=32'h0000_0001 -> dataout=31, done at t0+9; datain=0 -> dataout=32, done at t0+9.
//  3. datain=32'h00F0_0000 -> dataout=8, done at t0+4.
//     Then start again in the cycle after DONE -> accepted; result correct.
//  4. Start pulsed with a different datain during SCAN -> ignored.
//     The first op's result is unchanged and exactly one done pulse occurs.
//  5. rst_n low mid-SCAN of 32'h0000_0001 -> busy=0, done=0, dataout=0 immediately.
//     No done pulse after release.
//  6. CLZ_CLO_EN defined, mode=1, datain=32'hFFFF_0000 -> dataout=16.
//     mode=1, datain=32'hFFFF_FFFF -> dataout=32.

Source files
------------

// File: rtl/clz_pkg.sv
// Shared types and helpers for the sequential count-leading-zeros unit.
package clz_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } clz_state_t;

    function automatic int clz_cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/clz_chunk.sv
// Combinational priority encoder: leading-zero count of one STEP-bit chunk.
module clz_chunk #(
    parameter  int STEP = 4,
    localparam int LZ_W = $clog2(STEP + 1)
) (
    input  logic [STEP-1:0] in,
    output logic [LZ_W-1:0] lz,
    output logic            nz
);

    // first_hot marks the most significant set bit only.
    logic [STEP-1:0] first_hot;

    genvar gi;
    generate
        for (gi = 0; gi < STEP; gi++) begin : g_first
            if (gi == STEP - 1) begin : g_top
                assign first_hot[gi] = in[gi];
            end else begin : g_low
                assign first_hot[gi] = in[gi] & ~(|in[STEP-1:gi+1]);
            end
        end
    endgenerate

    always_comb begin
        lz = LZ_W'(STEP);
        for (int i = 0; i < STEP; i++) begin
            if (first_hot[i]) begin
                lz = LZ_W'(STEP - 1 - i);
            end
        end
    end

    assign nz = |in;

endmodule

// File: rtl/clz_seq.sv
// Multi-cycle CLZ unit scanning STEP bits per cycle from the MSB with start/busy/done.
// Define CLZ_CLO_EN to add the mode port (mode=1 counts leading ones).
module clz_seq
    import clz_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int STEP  = 4,
    localparam int CNT_W = clz_cnt_w(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] datain,
`ifdef CLZ_CLO_EN
    input  logic             mode,
`endif
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] dataout
);

    localparam int NCHUNK = (STEP >= 1) ? WIDTH / STEP : 1;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int LZ_W   = $clog2(STEP + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    generate
        if (STEP < 1) begin : g_bad_step
            $error("clz_seq: STEP must be at least 1");
        end else if (WIDTH % STEP != 0) begin : g_bad_width
            $error("clz_seq: WIDTH must be a multiple of STEP");
        end
    endgenerate

    clz_state_t       state_reg, state_next;
    logic [WIDTH-1:0] sh_reg, sh_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [IDX_W-1:0] idx_reg, idx_next;
    logic [CNT_W-1:0] dataout_reg, dataout_next;

    logic [WIDTH-1:0] operand;
    logic [LZ_W-1:0]  chunk_lz;
    logic             chunk_nz;

`ifdef CLZ_CLO_EN
    // Counting leading ones is counting leading zeros of the complement.
    assign operand = datain ^ {WIDTH{mode}};
`else
    assign operand = datain;
`endif

    clz_chunk #(.STEP(STEP)) u_chunk (
        .in (sh_reg[WIDTH-1 -: STEP]),
        .lz (chunk_lz),
        .nz (chunk_nz)
    );

    always_comb begin
        state_next   = state_reg;
        sh_next      = sh_reg;
        cnt_next     = cnt_reg;
        idx_next     = idx_reg;
        dataout_next = dataout_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    sh_next    = operand;
                    cnt_next   = '0;
                    idx_next   = '0;
                    state_next = SCAN;
                end
            end
            SCAN: begin
                // The result is published on entry to DONE so it is valid with the pulse.
                if (chunk_nz) begin
                    cnt_next     = cnt_reg + CNT_W'(chunk_lz);
                    dataout_next = cnt_next;
                    state_next   = DONE;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(STEP);
                    sh_next  = sh_reg << STEP;
                    idx_next = idx_reg + IDX_W'(1);
                    if (idx_reg == LAST_IDX) begin
                        dataout_next = cnt_next;
                        state_next   = DONE;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            sh_reg      <= '0;
            cnt_reg     <= '0;
            idx_reg     <= '0;
            dataout_reg <= '0;
        end else begin
            state_reg   <= state_next;
            sh_reg      <= sh_next;
            cnt_reg     <= cnt_next;
            idx_reg     <= idx_next;
            dataout_reg <= dataout_next;
        end
    end

    assign busy    = (state_reg != IDLE);
    assign done    = (state_reg == DONE);
    assign dataout = dataout_reg;

endmodule
